// File: rtl/n64_button_events_if.sv
// Bus bundle between the N64 poll source / APB reader and the button event queue.
// count is sized from DEPTH, so instantiate with the same DEPTH as the block.
interface n64_button_events_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic [31:0]   button_data;
  logic          data_valid;
  logic          rd_en;
  logic          overflow_clr;
  logic [23:0]   event_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output flush, button_data, data_valid, rd_en, overflow_clr,
    input  event_data, empty, count, overflow
  );

  modport slave (
    input  flush, button_data, data_valid, rd_en, overflow_clr,
    output event_data, empty, count, overflow
  );
endinterface

// File: rtl/n64_button_events.sv
// Turns changes between successive N64 button polls into press/release records
// and queues them in a first-word-fall-through FIFO for software to drain.
module n64_button_events #(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] BUTTON_MASK = 16'hFDFF
) (
  input logic                clk,
  input logic                reset,
  n64_button_events_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  // Button index i lives at poll bit 31-i; reverse so vector bit i == index i.
  function automatic logic [15:0] to_index_order(input logic [15:0] raw);
    for (int i = 0; i < 16; i++) begin
      to_index_order[i] = raw[15-i];
    end
  endfunction

  state_t        state_q, state_d;
  logic [15:0]   prev_q, prev_d;
  logic [15:0]   cur_q, cur_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   pending_q, pending_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [23:0]   mem_q [DEPTH];

  logic          clr;
  logic [15:0]   btn;
  logic [15:0]   changes;
  logic [3:0]    idx;
  logic [15:0]   pending_rem;
  logic          push;
  logic [23:0]   push_data;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic          pop;
  logic          unused_stick;

  assign clr          = reset | bus.flush;
  assign btn          = to_index_order(bus.button_data[31:16]);
  assign changes      = (btn ^ prev_q) & BUTTON_MASK;
  assign idx          = lowest_set(pending_q);
  assign pending_rem  = pending_q & ~(16'(1) << idx);
  assign unused_stick = ^bus.button_data[15:0];

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          seq_d     = seq_q + 16'd1;
          pending_d = changes;
          cur_d     = btn;
          prev_d    = btn;
          if (|changes) state_d = SCAN;
        end
      end
      SCAN: begin
        // Polls arriving here are dropped; prev keeps the last accepted poll.
        push      = 1'b1;
        push_data = {seq_q, 3'b000, cur_q[idx], idx};
        pending_d = pending_rem;
        if (pending_rem == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fullness uses the pre-pop count, so a same-cycle pop never rescues a push.
  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = push & ~full & ~clr;
  assign drop    = push & full & ~clr;
  assign pop     = bus.rd_en & (count_q != '0) & ~clr;

  always_comb begin
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    overflow_d = overflow_q;
    if (drop)                  overflow_d = 1'b1;
    else if (bus.overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      cur_q      <= '0;
      seq_q      <= '0;
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      seq_q      <= seq_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);
  assign bus.overflow   = overflow_q;
  assign bus.event_data = (count_q == '0) ? 24'h0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_n64_button_events.sv
// Bench for n64_button_events: directed vector table, corner-case sequences,
// then random traffic against a queue-based event model.
module tb_n64_button_events;
  localparam int          DEPTH = 16;
  localparam logic [15:0] MASK  = 16'hFDFF;

  logic clk = 1'b0;
  logic reset;

  n64_button_events_if #(.DEPTH(DEPTH)) bus ();

  n64_button_events #(.DEPTH(DEPTH), .BUTTON_MASK(MASK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: events waiting to be produced by the scan, one per cycle, and FIFO contents.
  logic [23:0] sq[$];
  logic [23:0] fq[$];
  logic [15:0] m_prev;
  logic [15:0] m_seq;
  bit          m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_clear();
    sq.delete();
    fq.delete();
    m_prev = '0;
    m_seq  = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input bit dv, input logic [31:0] bd, input bit rd,
                            input bit oc, input bit fl);
    bit          pushing;
    bit          full;
    bit          nb;
    logic [23:0] rec;
    if (fl) begin
      model_clear();
      return;
    end
    pushing = (sq.size() != 0);
    rec     = '0;
    if (pushing) rec = sq.pop_front();
    full = (fq.size() == DEPTH);
    if (rd && fq.size() != 0) void'(fq.pop_front());
    if (pushing && !full) fq.push_back(rec);
    if (pushing && full) m_ovf = 1'b1;
    else if (oc)         m_ovf = 1'b0;
    if (dv && !pushing) begin
      m_seq = m_seq + 16'd1;
      for (int i = 0; i < 16; i++) begin
        nb = bd[31-i];
        if (MASK[i] && nb != m_prev[i]) sq.push_back({m_seq, 3'b000, nb, 4'(i)});
        m_prev[i] = nb;
      end
    end
  endtask

  task automatic step(input bit dv, input logic [31:0] bd, input bit rd,
                      input bit oc, input bit fl);
    bus.data_valid   = dv;
    bus.button_data  = bd;
    bus.rd_en        = rd;
    bus.overflow_clr = oc;
    bus.flush        = fl;
    @(posedge clk);
    model_edge(dv, bd, rd, oc, fl);
    #1;
    chk("model_empty", 32'(bus.empty), 32'(fq.size() == 0));
    chk("model_count", 32'(bus.count), 32'(fq.size()));
    chk("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("model_head", 32'(bus.event_data), (fq.size() == 0) ? 32'h0 : 32'(fq[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic poll(input logic [31:0] bd);
    step(1'b1, bd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          dv;
    logic [31:0] bd;
    bit          rd;
    bit          e_empty;
    int          e_count;
    logic [23:0] e_head;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [15:0] rnd_btn;
    logic [31:0] bd;

    tbl[0]  = '{1'b1, 32'h8000_1234, 1'b0, 1'b1, 0, 24'h000000};
    tbl[1]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1, 24'h000110};
    tbl[2]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 24'h000000};
    tbl[3]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 0, 24'h000000};
    tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1, 24'h000200};
    tbl[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 24'h000000};
    tbl[6]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 0, 24'h000000};
    tbl[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 0, 24'h000000};
    tbl[8]  = '{1'b1, 32'hC010_0000, 1'b0, 1'b1, 0, 24'h000000};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1, 24'h000410};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 2, 24'h000410};
    tbl[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 3, 24'h000410};
    tbl[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 2, 24'h000411};
    tbl[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, 24'h00041B};
    tbl[14] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 24'h000000};
    tbl[15] = '{1'b1, 32'hC050_0000, 1'b0, 1'b1, 0, 24'h000000};
    tbl[16] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 0, 24'h000000};

    reset            = 1'b1;
    bus.flush        = 1'b0;
    bus.data_valid   = 1'b0;
    bus.button_data  = '0;
    bus.rd_en        = 1'b0;
    bus.overflow_clr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", 32'(bus.empty), 32'h1);
    chk("reset_count", 32'(bus.count), 32'h0);
    chk("reset_overflow", 32'(bus.overflow), 32'h0);
    chk("reset_head", 32'(bus.event_data), 32'h0);
    reset = 1'b0;

    for (int v = 0; v < 17; v++) begin
      step(tbl[v].dv, tbl[v].bd, tbl[v].rd, 1'b0, 1'b0);
      chk($sformatf("vec%0d_empty", v), 32'(bus.empty), 32'(tbl[v].e_empty));
      chk($sformatf("vec%0d_count", v), 32'(bus.count), 32'(tbl[v].e_count));
      chk($sformatf("vec%0d_head", v), 32'(bus.event_data), 32'(tbl[v].e_head));
    end

    // Poll during a scan is ignored; its change shows up on the next accepted poll.
    poll(32'h0000_0000);
    poll(32'h8000_0000);
    idle(2);
    chk("ign_count", 32'(bus.count), 32'd3);
    chk("ign_head0", 32'(bus.event_data), 32'h000600);
    rd1();
    chk("ign_head1", 32'(bus.event_data), 32'h000601);
    rd1();
    chk("ign_head2", 32'(bus.event_data), 32'h00060B);
    rd1();
    poll(32'h8000_0000);
    idle(1);
    chk("ign_later", 32'(bus.event_data), 32'h000710);
    chk("ign_later_cnt", 32'(bus.count), 32'd1);

    // Overflow: 30 events into a 16-deep FIFO.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    poll(32'hFFFF_0000);
    idle(15);
    poll(32'h0000_0000);
    idle(15);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_flag", 32'(bus.overflow), 32'h1);
    chk("ovf_head", 32'(bus.event_data), 32'h000110);
    poll(32'hFFFF_0000);
    rd1();
    chk("ovf_pop_count", 32'(bus.count), 32'd15);
    chk("ovf_pop_flag", 32'(bus.overflow), 32'h1);
    idle(14);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(bus.overflow), 32'h0);
    chk("ovf_clr_count", 32'(bus.count), 32'd16);

    // Flush mid-scan with 5 entries queued.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    poll(32'hFFFF_0000);
    idle(5);
    chk("fl_pre_count", 32'(bus.count), 32'd5);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("fl_empty", 32'(bus.empty), 32'h1);
    chk("fl_count", 32'(bus.count), 32'h0);
    idle(1);
    chk("fl_abort", 32'(bus.empty), 32'h1);
    poll(32'h8000_0000);
    idle(1);
    chk("fl_seq1", 32'(bus.event_data), 32'h000110);

    // Random traffic.
    rnd_btn = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rnd_btn = 16'($urandom);
      else rnd_btn = rnd_btn ^ (16'h1 << $urandom_range(0, 15));
      bd = {rnd_btn, 16'($urandom)};
      step($urandom_range(0, 2) == 0, bd, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
